// File: rtl/fft8_bin_serializer_if.sv
// Valid/ready bundle for the FFT bin serializer: parallel frame in, serial bins out.
interface fft8_bin_serializer_if #(
    parameter int DATA_W = 16,
    parameter int N      = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [N*DATA_W-1:0]   in_real;
    logic [N*DATA_W-1:0]   in_im;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_real;
    logic [DATA_W-1:0]     out_im;
    logic [2:0]            out_index;
    logic                  out_last;

    // Driver side: supplies frames, consumes bins.
    modport master (
        output in_valid, in_real, in_im, out_ready,
        input  in_ready, out_valid, out_real, out_im, out_index, out_last
    );

    // Serializer side.
    modport slave (
        input  in_valid, in_real, in_im, out_ready,
        output in_ready, out_valid, out_real, out_im, out_index, out_last
    );
endinterface

// File: rtl/fft8_bin_serializer.sv
// Captures an 8-point FFT frame into one of two banks and streams the bins
// out one per cycle, optionally undoing the FFT's bit-reversed ordering.
module fft8_bin_serializer #(
    parameter int DATA_W      = 16,
    parameter int N           = 8,
    parameter bit BIT_REVERSE = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fft8_bin_serializer_if.slave    bus,
    output logic [7:0]              frame_cnt
);

    localparam logic [2:0] LAST_IDX = 3'(N - 1);

    // Bank storage: bank b, element j.
    logic [DATA_W-1:0] bank_re [2][N];
    logic [DATA_W-1:0] bank_im [2][N];

    logic [1:0] full;
    logic [1:0] full_nxt;
    logic       wr_sel;
    logic       rd_sel;
    logic [2:0] idx;
    logic [2:0] rd_pos;
    logic       capture;
    logic       xfer;
    logic       drain_done;

    function automatic logic [2:0] bitrev3(input logic [2:0] i);
        return {i[0], i[1], i[2]};
    endfunction

    // in_ready comes only from state, so there is no path from in_valid/out_ready.
    assign bus.in_ready  = ~full[wr_sel];
    assign bus.out_valid = full[rd_sel];
    assign bus.out_index = idx;
    assign bus.out_last  = full[rd_sel] && (idx == LAST_IDX);

    assign capture    = bus.in_valid && bus.in_ready;
    assign xfer       = bus.out_valid && bus.out_ready;
    assign drain_done = xfer && (idx == LAST_IDX);

    assign rd_pos = BIT_REVERSE ? bitrev3(idx) : idx;

    // Read mux; forced to zero when nothing is buffered so reset shows clean outputs.
    assign bus.out_real = full[rd_sel] ? bank_re[rd_sel][rd_pos] : '0;
    assign bus.out_im   = full[rd_sel] ? bank_im[rd_sel][rd_pos] : '0;

    // Next bank-full flags: a drain and a capture always target different banks.
    always_comb begin
        // NOTE: default first so every path assigns full_nxt and no latch is inferred.
        full_nxt = full;
        if (drain_done) full_nxt[rd_sel] = 1'b0;
        if (capture)    full_nxt[wr_sel] = 1'b1;
    end

    // Control state: bank flags, bank pointers, bin index and drained-frame count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full      <= '0;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            idx       <= '0;
            frame_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            full <= full_nxt;
            if (capture) wr_sel <= ~wr_sel;
            if (xfer) begin
                if (idx == LAST_IDX) begin
                    idx       <= '0;
                    rd_sel    <= ~rd_sel;
                    frame_cnt <= frame_cnt + 8'd1;
                end else begin
                    idx <= idx + 3'd1;
                end
            end
        end
    end

    // Frame capture into the write bank.
    // NOTE: the banks carry no reset; the full flags decide whether their contents mean anything.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int j = 0; j < N; j++) begin
                bank_re[wr_sel][j] <= bus.in_real[j*DATA_W +: DATA_W];
                bank_im[wr_sel][j] <= bus.in_im[j*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_fft8_bin_serializer.sv
// Randomized bench for fft8_bin_serializer against a frame-queue reference model.
module tb_fft8_bin_serializer;

    localparam int DATA_W = 16;
    localparam int N      = 8;

    typedef struct packed {
        logic [N-1:0][DATA_W-1:0] re;
        logic [N-1:0][DATA_W-1:0] im;
    } frame_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] frame_cnt;
    logic [7:0] frame_cnt_nr;

    int total = 0;
    int bad   = 0;

    // Reference model: frames waiting or draining, position in the head frame, drained count.
    frame_t q[$];
    frame_t cur;
    int     pos = 0;
    int     cnt = 0;

    fft8_bin_serializer_if #(.DATA_W(DATA_W), .N(N)) bus ();
    fft8_bin_serializer_if #(.DATA_W(DATA_W), .N(N)) bus_nr ();

    assign bus_nr.in_valid  = bus.in_valid;
    assign bus_nr.in_real   = bus.in_real;
    assign bus_nr.in_im     = bus.in_im;
    assign bus_nr.out_ready = bus.out_ready;

    fft8_bin_serializer #(.DATA_W(DATA_W), .N(N), .BIT_REVERSE(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .frame_cnt (frame_cnt)
    );

    fft8_bin_serializer #(.DATA_W(DATA_W), .N(N), .BIT_REVERSE(1'b0)) dut_nr (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_nr.slave),
        .frame_cnt (frame_cnt_nr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int bitrev(input int i);
        return ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        for (int k = 0; k < N; k++) begin
            f.re[k] = 16'($urandom);
            f.im[k] = 16'($urandom);
        end
        return f;
    endfunction

    // One clock: check outputs against the model, drive inputs, advance the model.
    // Entered and left at a falling edge.
    task automatic cycle(input logic iv, input logic ordy);
        bit     cap;
        bit     xfer;
        frame_t h;
        check("in_ready",  bus.in_ready,  q.size() < 2);
        check("out_valid", bus.out_valid, q.size() > 0);
        check("out_index", bus.out_index, pos);
        check("out_last",  bus.out_last,  q.size() > 0 && pos == N - 1);
        check("frame_cnt", frame_cnt,     cnt % 256);
        if (q.size() > 0) begin
            h = q[0];
            check("out_real",    bus.out_real,    h.re[bitrev(pos)]);
            check("out_im",      bus.out_im,      h.im[bitrev(pos)]);
            check("nr_out_real", bus_nr.out_real, h.re[pos]);
            check("nr_out_im",   bus_nr.out_im,   h.im[pos]);
        end
        bus.in_valid  = iv;
        bus.in_real   = cur.re;
        bus.in_im     = cur.im;
        bus.out_ready = ordy;
        cap  = iv && (q.size() < 2);
        xfer = (q.size() > 0) && ordy;
        @(posedge clk);
        if (xfer) begin
            if (pos == N - 1) begin
                void'(q.pop_front());
                pos = 0;
                cnt++;
            end else begin
                pos++;
            end
        end
        if (cap) begin
            q.push_back(cur);
            cur = rand_frame();
        end
        @(negedge clk);
    endtask

    initial begin
        int start;
        int guard;
        bus.in_valid  = 1'b0;
        bus.in_real   = '0;
        bus.in_im     = '0;
        bus.out_ready = 1'b0;
        cur = rand_frame();

        // Reset values, then idle.
        repeat (3) @(negedge clk);
        check("rst_in_ready",  bus.in_ready,  1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_real",  bus.out_real,  0);
        check("rst_out_im",    bus.out_im,    0);
        check("rst_out_index", bus.out_index, 0);
        check("rst_out_last",  bus.out_last,  0);
        check("rst_frame_cnt", frame_cnt,     0);
        rst_n = 1'b1;
        repeat (3) cycle(1'b0, 1'b0);

        // Single known frame, continuous drain.
        for (int j = 0; j < N; j++) begin
            cur.re[j] = 16'h0100 + 16'(j);
            cur.im[j] = 16'hF000 + 16'(j);
        end
        cycle(1'b1, 1'b1);
        repeat (9) cycle(1'b0, 1'b1);
        check("single_frame_cnt", frame_cnt, 1);

        // Backpressure at index 3.
        cycle(1'b1, 1'b1);
        guard = 0;
        while (pos != 3 && guard < 20) begin
            cycle(1'b0, 1'b1);
            guard++;
        end
        check("bp_reach_idx3", pos, 3);
        repeat (5) cycle(1'b0, 1'b0);
        repeat (9) cycle(1'b0, 1'b1);

        // Ping-pong fill: A and B taken, C held until A drains.
        repeat (5)  cycle(1'b1, 1'b0);
        repeat (20) cycle(1'b1, 1'b1);
        repeat (20) cycle(1'b0, 1'b1);

        // Streaming through a full frame_cnt wrap.
        start = cnt;
        for (int i = 0; i < 256 * N + 40 && cnt < start + 256; i++)
            cycle(1'b1, 1'b1);
        check("wrap_frame_cnt", frame_cnt, 8'(start));
        repeat (20) cycle(1'b0, 1'b1);

        // Random traffic on both sides.
        for (int i = 0; i < 2000; i++)
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
        repeat (20) cycle(1'b0, 1'b1);

        // Reset in the middle of a drain.
        cycle(1'b1, 1'b1);
        guard = 0;
        while (pos != 5 && guard < 20) begin
            cycle(1'b0, 1'b1);
            guard++;
        end
        check("mid_reach_idx5", pos, 5);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_in_ready",  bus.in_ready,  1);
        check("mid_rst_out_index", bus.out_index, 0);
        check("mid_rst_frame_cnt", frame_cnt,     0);
        q.delete();
        pos = 0;
        cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b1);
        repeat (10) cycle(1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft8_bin_serializer.md
Name: fft8_bin_serializer

Overview:
- Receives one frame of eight parallel complex FFT results from an 8-point FFT stage and streams the bins out one per cycle on a valid/ready interface.
- Two-bank ping-pong buffer: a new frame can be accepted while the previous frame drains.
- Optional bit-reversal reorder so downstream logic sees bins in natural order 0..7.
- Sits between the FFT butterfly network and the serial result consumer (UART/DMA/capture logic).

Parameters:
- DATA_W, 16, width of each real and imaginary component.
- N, 8, points per frame; power of two, fixed at 8 for this block.
- BIT_REVERSE, 1, 1 = output position i carries stored element bitrev3(i); 0 = carries element i.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  a frame is present on in_real/in_im.
- in_ready  out  1  block can capture a frame this cycle.
- in_real  in  N*DATA_W  packed real parts; element j at bits [j*DATA_W +: DATA_W].
- in_im  in  N*DATA_W  packed imaginary parts, same packing as in_real.
- out_valid  out  1  out_real/out_im/out_index/out_last are valid.
- out_ready  in  1  consumer accepts the current bin.
- out_real  out  DATA_W  real part of the current bin.
- out_im  out  DATA_W  imaginary part of the current bin.
- out_index  out  3  bin number i of the current output, 0..7.
- out_last  out  1  high with out_index == N-1.
- frame_cnt  out  8  count of frames fully drained; wraps 255 -> 0.

Behaviour:
- Reset (async assert, sync release): both bank-full flags = 0, wr_sel = 0, rd_sel = 0, index = 0, frame_cnt = 0.
  - Outputs at reset: out_valid = 0, out_real = out_im = 0, out_index = 0, out_last = 0, in_ready = 1.
- in_ready = NOT full[wr_sel], derived from registers only. It never depends on in_valid or out_ready combinationally.
- Capture: when in_valid && in_ready on edge T:
  - all 2*N words are written into bank wr_sel;
  - full[wr_sel] is set;
  - wr_sel toggles.
- in_valid while in_ready = 0 has no effect. The frame is not captured, and the source must hold it.
- Read side:
  - out_valid = full[rd_sel].
  - out_real/out_im = bank[rd_sel] element p, where p = bitrev3(index) if BIT_REVERSE = 1, else p = index. bitrev3 maps 1<->4, 3<->6; 0, 2, 5, 7 map to themselves.
  - out_index = index. out_last = (index == 7) && out_valid.
- Output transfer on out_valid && out_ready:
  - if index < 7, index increments;
  - if index == 7, index returns to 0, full[rd_sel] clears, rd_sel toggles, and frame_cnt increments.
- Stall: while out_valid && !out_ready, out_real, out_im, out_index and out_last hold stable.
- Latency:
  - a frame captured at edge T with its read bank idle gives out_valid = 1 in cycle T+1, showing bin 0;
  - with out_ready held high, bins 0..7 appear in cycles T+1..T+8.
- Throughput: with both sides always ready, one frame is accepted per 8 cycles with no bubbles on the output.
- Simultaneous events:
  - a capture into one bank and the last-bin transfer from the other bank in the same edge are both performed;
  - capture into the bank being freed on that same edge is not allowed, because in_ready was computed before the edge.
- Both banks full: in_ready = 0 until the out_last transfer, then in_ready = 1 on the following cycle.
- Reset mid-frame: partially drained and buffered frames are discarded. frame_cnt is not incremented for them.
- Data is passed through unmodified: no scaling, rounding or sign handling.

Test Plan:
- Reset then idle: rst_n low then high, no in_valid -> in_ready = 1, out_valid = 0, frame_cnt = 0.
- Single frame, BIT_REVERSE = 1, out_ready = 1:
  - stimulus: element j real = 16'h0100+j, im = 16'hF000+j, captured at edge T;
  - required: cycles T+1..T+8 show out_index 0..7 with out_real 0100, 0104, 0102, 0106, 0101, 0105, 0103, 0107;
  - required: out_last only at index 7; frame_cnt = 1 afterwards.
- Backpressure: out_ready = 0 for 5 cycles at index 3 -> outputs frozen at index 3 values, and index 3 is delivered exactly once after release.
- Ping-pong and full:
  - stimulus: three frames A, B, C offered back-to-back with out_ready = 0;
  - required: A and B captured; in_ready = 0 while C is held;
  - required: releasing out_ready drains A, and C is captured the cycle after A's out_last.
- Streaming: continuous frames with out_ready = 1 -> 8 frames delivered in 64 consecutive out_valid cycles, frame_cnt = 8.
  - Wrap: extend the run to 256 frames -> frame_cnt wraps to 0.
- Reset mid-drain: rst_n pulsed low at index 5 -> out_valid = 0 immediately, in_ready = 1, and the next captured frame starts at index 0.
